avalon_note_sequencer: RTL and testbench

Hardware score player and Avalon-MM master that drives the `avalon_FreqSynth` register slave. It reads 16-bit note events from a synchronous score ROM and writes note, volume and playing registers over Avalon-MM. It holds each note for its programmed duration, so a song plays without Nios II intervention. `start`/`stop`/`busy`/`done` connect to PIO conduits for software control.

---
 rtl/avalon_note_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_avalon_note_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_note_sequencer.sv
// Score ROM player: fetches 16-bit note events and drives the
// avalon_FreqSynth note/volume/playing registers over Avalon-MM.
module avalon_note_sequencer #(
   parameter int ADDR_W         = 8,
   parameter int TICKS_PER_BEAT = 12500000,
   parameter int GAP_CYCLES     = 500000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [1:0]        avm_address,
   output logic [7:0]        avm_writedata,
   output logic              avm_write,
   output logic              avm_chipselect,
   input  logic              avm_waitrequest
);

   localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TICKS_PER_BEAT - 1);
   localparam logic [GW-1:0] GMAX =
      GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_WR_NOTE, S_WR_VOL,
      S_WR_PLAY, S_HOLD, S_WR_OFF, S_GAP, S_WR_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [5:0]        beat_q, beat_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [1:0]        vol_q, vol_d;
   logic              rest_q, rest_d;
   logic              pend_q, pend_d;
   logic              done_q, done_d;
   logic              wr_q, wr_d;
   logic [1:0]        adr_q, adr_d;
   logic [7:0]        dat_q, dat_d;

   logic       halt;
   logic       xfer;
   logic [5:0] ev_dur;
   logic [7:0] ev_note;

   assign ev_dur  = rom_data[15:10];
   assign ev_note = rom_data[7:0];
   // A stop seen during a stalled write is remembered until it can act.
   assign halt    = stop | pend_q;
   assign xfer    = wr_q & ~avm_waitrequest;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      tick_d  = tick_q;
      gap_d   = gap_q;
      vol_d   = vol_q;
      rest_d  = rest_q;
      pend_d  = pend_q | stop;
      done_d  = 1'b0;
      wr_d    = wr_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      unique case (state_q)
         S_IDLE: begin
            pend_d = 1'b0;
            if (start && !stop) begin
               state_d = S_FETCH;
               ptr_d   = '0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            beat_d = ev_dur;
            tick_d = TMAX;
            vol_d  = rom_data[9:8];
            rest_d = (ev_note == 8'd0);
            wr_d   = 1'b1;
            adr_d  = 2'd0;
            dat_d  = 8'd0;
            if (ev_dur == 6'd0) begin
               state_d = S_WR_STOP;
            end else if (ev_note == 8'd0) begin
               state_d = S_WR_OFF;
            end else begin
               state_d = S_WR_NOTE;
               adr_d   = 2'd1;
               dat_d   = ev_note;
            end
         end
         S_WR_NOTE: if (xfer) begin
            state_d = S_WR_VOL;
            adr_d   = 2'd2;
            dat_d   = {6'd0, vol_q};
         end
         S_WR_VOL: if (xfer) begin
            state_d = S_WR_PLAY;
            adr_d   = 2'd0;
            dat_d   = 8'h01;
         end
         S_WR_PLAY: if (xfer) begin
            state_d = S_HOLD;
            wr_d    = 1'b0;
         end
         S_HOLD: begin
            if (tick_q != '0) begin
               tick_d = tick_q - TW'(1);
            end else if (beat_q != 6'd1) begin
               beat_d = beat_q - 6'd1;
               tick_d = TMAX;
            end else if (!rest_q) begin
               state_d = S_WR_OFF;
               wr_d    = 1'b1;
               adr_d   = 2'd0;
               dat_d   = 8'd0;
            end else if (GAP_CYCLES == 0) begin
               state_d = S_FETCH;
               ptr_d   = ptr_q + ADDR_W'(1);
            end else begin
               state_d = S_GAP;
               gap_d   = GMAX;
            end
         end
         S_WR_OFF: if (xfer) begin
            wr_d = 1'b0;
            if (rest_q) begin
               state_d = S_HOLD;
            end else if (GAP_CYCLES == 0) begin
               state_d = S_FETCH;
               ptr_d   = ptr_q + ADDR_W'(1);
            end else begin
               state_d = S_GAP;
               gap_d   = GMAX;
            end
         end
         S_GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GW'(1);
            end else begin
               state_d = S_FETCH;
               ptr_d   = ptr_q + ADDR_W'(1);
            end
         end
         S_WR_STOP: if (xfer) begin
            state_d = S_IDLE;
            wr_d    = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // Stop overrides everything except an unfinished bus transfer.
      if (halt && ((state_q inside {S_FETCH, S_DECODE, S_HOLD, S_GAP}) ||
          (xfer && (state_q inside {S_WR_NOTE, S_WR_VOL,
                                    S_WR_PLAY, S_WR_OFF})))) begin
         state_d = S_WR_STOP;
         ptr_d   = ptr_q;
         wr_d    = 1'b1;
         adr_d   = 2'd0;
         dat_d   = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         beat_q  <= '0;
         tick_q  <= '0;
         gap_q   <= '0;
         vol_q   <= '0;
         rest_q  <= 1'b0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
         tick_q  <= tick_d;
         gap_q   <= gap_d;
         vol_q   <= vol_d;
         rest_q  <= rest_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         wr_q    <= wr_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign done           = done_q;
   assign rom_addr       = ptr_q;
   assign avm_address    = adr_q;
   assign avm_writedata  = dat_q;
   assign avm_write      = wr_q;
   assign avm_chipselect = wr_q;

endmodule

// File: tb/tb_avalon_note_sequencer.sv
// Directed bench for avalon_note_sequencer: synchronous ROM model,
// optional 3-cycle waitrequest slave, write log with cycle stamps.
module tb_avalon_note_sequencer;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          busy;
   logic          done;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_data;
   logic [1:0]    avm_address;
   logic [7:0]    avm_writedata;
   logic          avm_write;
   logic          avm_chipselect;
   logic          avm_waitrequest;

   logic [15:0] rom [4];
   int          cyc = 0;
   int          total = 0;
   int          passes = 0;
   bit          stall_en = 1'b0;
   int          wcnt = 0;

   typedef struct {
      logic [1:0]    a;
      logic [7:0]    d;
      int            c;
      logic [AW-1:0] p;
   } wr_t;
   wr_t wlog[$];

   logic       prev_stall = 1'b0;
   logic [1:0] prev_a = '0;
   logic [7:0] prev_d = '0;

   avalon_note_sequencer #(
      .ADDR_W(AW), .TICKS_PER_BEAT(4), .GAP_CYCLES(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .busy(busy), .done(done), .rom_addr(rom_addr),
      .rom_data(rom_data), .avm_address(avm_address),
      .avm_writedata(avm_writedata), .avm_write(avm_write),
      .avm_chipselect(avm_chipselect),
      .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_data <= rom[rom_addr];

   assign avm_waitrequest = stall_en && avm_write && (wcnt < 3);

   always @(posedge clk) begin
      if (!reset_n || (avm_write && !avm_waitrequest)) wcnt <= 0;
      else if (avm_write) wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (prev_stall)
            chk("stall_stable", {21'd0, avm_write, avm_address, avm_writedata},
                {21'd0, 1'b1, prev_a, prev_d});
         if (avm_write) chk("cs_high", avm_chipselect, 1);
         else chk("cs_low", avm_chipselect, 0);
         if (avm_write && !avm_waitrequest)
            wlog.push_back('{avm_address, avm_writedata, cyc, rom_addr});
      end
      prev_stall <= reset_n && avm_write && avm_waitrequest;
      prev_a     <= avm_address;
      prev_d     <= avm_writedata;
   end

   task automatic kick(output int n0);
      @(negedge clk);
      n0 = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic post_done(input string tag, input int at, input int exp);
      chk({tag, "_done_cyc"}, at, exp);
      chk({tag, "_busy_low"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   task automatic chk_wr(input string tag, input int i, input logic [1:0] a,
                         input logic [7:0] d, input int c);
      wr_t w;
      w.a = 'x;
      w.d = 'x;
      w.c = -1;
      w.p = '0;
      if (i < wlog.size()) w = wlog[i];
      chk({tag, "_addr"}, w.a, a);
      chk({tag, "_data"}, w.d, d);
      chk({tag, "_cyc"}, w.c, c);
   endtask

   function automatic int count_notes();
      int n = 0;
      foreach (wlog[i]) if (wlog[i].a == 2'd1) n++;
      return n;
   endfunction

   initial begin
      int n0;
      int at;
      int k;
      int seen;
      logic [AW-1:0] exp_p [6];
      logic [7:0]    exp_n [6];
      exp_p = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      exp_n = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2};
      rom = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

      repeat (3) @(negedge clk);
      chk("reset_outs", {busy, done, avm_write, avm_chipselect,
          avm_address, avm_writedata, rom_addr}, 0);
      reset_n = 1'b1;

      // start and stop together in IDLE
      @(negedge clk);
      start = 1'b1;
      stop = 1'b1;
      repeat (3) @(negedge clk);
      chk("t0_idle_busy", busy, 0);
      start = 1'b0;
      stop = 1'b0;
      @(negedge clk);
      chk("t0_no_writes", wlog.size(), 0);

      // note 0x45 vol 2 dur 2, then end marker
      rom[0] = 16'h0A45;
      rom[1] = 16'h0000;
      wlog.delete();
      kick(n0);
      chk("t1_busy", busy, 1);
      wait_done(80, at);
      post_done("t1", at, n0 + 20);
      chk("t1_count", wlog.size(), 5);
      chk_wr("t1_w0", 0, 2'd1, 8'h45, n0 + 3);
      chk_wr("t1_w1", 1, 2'd2, 8'h02, n0 + 4);
      chk_wr("t1_w2", 2, 2'd0, 8'h01, n0 + 5);
      chk_wr("t1_w3", 3, 2'd0, 8'h00, n0 + 14);
      chk_wr("t1_w4", 4, 2'd0, 8'h00, n0 + 19);

      // same score, 3 stall cycles per write
      stall_en = 1'b1;
      wlog.delete();
      kick(n0);
      wait_done(120, at);
      post_done("t2", at, n0 + 35);
      chk("t2_count", wlog.size(), 5);
      chk_wr("t2_w0", 0, 2'd1, 8'h45, n0 + 6);
      chk_wr("t2_w1", 1, 2'd2, 8'h02, n0 + 10);
      chk_wr("t2_w2", 2, 2'd0, 8'h01, n0 + 14);
      chk_wr("t2_w3", 3, 2'd0, 8'h00, n0 + 26);
      chk_wr("t2_w4", 4, 2'd0, 8'h00, n0 + 34);
      stall_en = 1'b0;

      // rest of one beat, then end marker
      rom[0] = 16'h0400;
      wlog.delete();
      kick(n0);
      wait_done(80, at);
      post_done("t3", at, n0 + 13);
      chk("t3_count", wlog.size(), 2);
      chk_wr("t3_w0", 0, 2'd0, 8'h00, n0 + 3);
      chk_wr("t3_w1", 1, 2'd0, 8'h00, n0 + 12);

      // stop during HOLD
      rom[0] = 16'h0A45;
      wlog.delete();
      kick(n0);
      repeat (7) @(negedge clk);
      stop = 1'b1;
      wait_done(40, at);
      stop = 1'b0;
      post_done("t4a", at, n0 + 10);
      chk("t4a_count", wlog.size(), 4);
      chk_wr("t4a_w2", 2, 2'd0, 8'h01, n0 + 5);
      chk_wr("t4a_w3", 3, 2'd0, 8'h00, n0 + 9);

      // stop during stalled WR_VOL
      stall_en = 1'b1;
      wlog.delete();
      kick(n0);
      repeat (7) @(negedge clk);
      stop = 1'b1;
      wait_done(60, at);
      stop = 1'b0;
      post_done("t4b", at, n0 + 15);
      chk("t4b_count", wlog.size(), 3);
      chk_wr("t4b_w0", 0, 2'd1, 8'h45, n0 + 6);
      chk_wr("t4b_w1", 1, 2'd2, 8'h02, n0 + 10);
      chk_wr("t4b_w2", 2, 2'd0, 8'h00, n0 + 14);
      stall_en = 1'b0;

      // no end marker: pointer wraps
      rom = '{16'h0401, 16'h0402, 16'h0403, 16'h0404};
      wlog.delete();
      kick(n0);
      seen = 0;
      for (int i = 0; i < 200 && seen < 6; i++) begin
         @(negedge clk);
         seen = count_notes();
      end
      chk("t5_six_events", seen, 6);
      stop = 1'b1;
      wait_done(40, at);
      stop = 1'b0;
      chk("t5_done_seen", at >= 0, 1);
      chk("t5_note_total", count_notes(), 6);
      k = 0;
      foreach (wlog[i]) begin
         if (wlog[i].a == 2'd1) begin
            if (k < 6) begin
               chk($sformatf("t5_ptr%0d", k), wlog[i].p, exp_p[k]);
               chk($sformatf("t5_note%0d", k), wlog[i].d, exp_n[k]);
            end
            k++;
         end
      end

      // async reset in the second event's WR_PLAY
      wlog.delete();
      kick(n0);
      seen = 0;
      for (int i = 0; i < 60 && seen == 0; i++) begin
         @(negedge clk);
         if (avm_write && avm_address == 2'd0 && avm_writedata == 8'h01 &&
             rom_addr == 2'd1) seen = 1;
      end
      chk("t6_in_play", seen, 1);
      #2 reset_n = 1'b0;
      #1 chk("t6_async_reset", {busy, done, avm_write, avm_chipselect,
             avm_address, avm_writedata, rom_addr}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // start held while busy
      rom = '{16'h0A45, 16'h0000, 16'h0000, 16'h0000};
      wlog.delete();
      kick(n0);
      repeat (7) @(negedge clk);
      start = 1'b1;
      repeat (10) @(negedge clk);
      start = 1'b0;
      wait_done(40, at);
      post_done("t7", at, n0 + 20);
      repeat (5) @(negedge clk);
      chk("t7_idle", busy, 0);
      chk("t7_count", wlog.size(), 5);
      chk_wr("t7_w3", 3, 2'd0, 8'h00, n0 + 14);
      chk_wr("t7_w4", 4, 2'd0, 8'h00, n0 + 19);
      chk("t7_last_ptr", wlog.size() == 5 ? wlog[4].p : 2'bxx, 2'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d/%0d", passes, total);
      $fatal(1, "watchdog");
   end

endmodule
